// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over req/gnt/rvalid, buffers words for decode, flushes on redirect.
// Optional FETCH_PERF_CNT_EN adds stall_cnt_o (cycles decode was ready but starved).
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FLUSH} state_t;

    state_t             r_state, w_state;
    logic [31:0]        r_fetch_pc, w_fetch_pc;
    logic [31:0]        r_flush_addr, w_flush_addr;
    logic               r_hold, w_hold;
    logic [CNT_W-1:0]   r_outst, w_outst;
    logic [CNT_W-1:0]   r_drop, w_drop;
    logic [31:0]        r_resp_pc, w_resp_pc;
    logic [PTR_W-1:0]   r_wptr, w_wptr, r_rptr, w_rptr;
    logic [CNT_W-1:0]   r_count, w_count, w_cnt_after_pop;
    logic               r_valid, w_valid;
    logic [31:0]        r_data, w_data, r_pc, w_pc;
    logic [31:0]        r_mem_data [FIFO_DEPTH];
    logic [31:0]        r_mem_pc   [FIFO_DEPTH];

    logic               w_req, w_gnt, w_rsp, w_rsp_drop, w_push, w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [31:0]        w_redir_pc;
    logic               w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

    // Handshakes, request rule, FSM, drop/PC bookkeeping and FIFO next state
    always_comb begin
        w_redir_pc   = {redirect_pc_i[31:2], 2'b00};
        w_pop        = r_valid && instr_ready_i;
        w_rsp        = imem_rvalid_i && (r_outst != '0);
        w_rsp_drop   = w_rsp && (r_drop != '0);
        w_push       = w_rsp && !w_rsp_drop && !redirect_valid_i;
        w_sum        = SUM_W'(r_count) + SUM_W'(r_outst) - SUM_W'(w_pop);
        w_req        = r_hold || ((r_state == ST_FETCH) && (w_sum < SUM_W'(FIFO_DEPTH)));
        w_gnt        = w_req && imem_gnt_i;

        w_state      = r_state;
        w_fetch_pc   = r_fetch_pc;
        w_flush_addr = r_flush_addr;
        w_drop       = r_drop;
        w_resp_pc    = r_resp_pc;
        w_hold       = w_req && !imem_gnt_i;
        w_outst      = r_outst + CNT_W'(w_gnt) - CNT_W'(w_rsp);

        case (r_state)
            ST_RESET: w_state = ST_FETCH;
            ST_FETCH: begin
                if (w_gnt) w_fetch_pc = r_fetch_pc + 32'd4;
                if (redirect_valid_i && w_hold) begin
                    w_state      = ST_FLUSH;
                    w_flush_addr = r_fetch_pc;
                end
            end
            ST_FLUSH: if (w_gnt) w_state = ST_FETCH;
            default:  w_state = ST_RESET;
        endcase

        if (w_rsp_drop) w_drop = r_drop - CNT_W'(1);
        // The stale request finally granted during a flush is one more word to discard
        if ((r_state == ST_FLUSH) && w_gnt) w_drop = w_drop + CNT_W'(1);

        if (redirect_valid_i) begin
            w_drop     = w_outst;
            w_resp_pc  = w_redir_pc;
            w_fetch_pc = w_redir_pc;
        end else if (w_push) begin
            w_resp_pc  = r_resp_pc + 32'd4;
        end

        w_rptr          = w_pop  ? r_rptr + PTR_W'(1) : r_rptr;
        w_wptr          = w_push ? r_wptr + PTR_W'(1) : r_wptr;
        w_cnt_after_pop = r_count - CNT_W'(w_pop);
        w_count         = w_cnt_after_pop + CNT_W'(w_push);
        w_data          = r_data;
        w_pc            = r_pc;
        // Bypass the incoming word straight to the head register when the buffer would be empty
        if (w_push && (w_cnt_after_pop == '0)) begin
            w_data = imem_rdata_i;
            w_pc   = r_resp_pc;
        end else if (w_cnt_after_pop != '0) begin
            w_data = r_mem_data[w_rptr];
            w_pc   = r_mem_pc[w_rptr];
        end
        if (redirect_valid_i) begin
            w_count = '0;
            w_rptr  = '0;
            w_wptr  = '0;
        end
        w_valid = (w_count != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_RESET;
            r_fetch_pc   <= RESET_PC;
            r_flush_addr <= RESET_PC;
            r_hold       <= 1'b0;
            r_outst      <= '0;
            r_drop       <= '0;
            r_resp_pc    <= RESET_PC;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_pc         <= '0;
        end else begin
            r_state      <= w_state;
            r_fetch_pc   <= w_fetch_pc;
            r_flush_addr <= w_flush_addr;
            r_hold       <= w_hold;
            r_outst      <= w_outst;
            r_drop       <= w_drop;
            r_resp_pc    <= w_resp_pc;
            r_wptr       <= w_wptr;
            r_rptr       <= w_rptr;
            r_count      <= w_count;
            r_valid      <= w_valid;
            r_data       <= w_data;
            r_pc         <= w_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= imem_rdata_i;
            r_mem_pc[r_wptr]   <= r_resp_pc;
        end
    end

    // During a flush the held request keeps its original address until granted
    assign imem_req_o    = w_req;
    assign imem_addr_o   = (r_state == ST_FLUSH) ? r_flush_addr : r_fetch_pc;
    assign instr_valid_o = r_valid;
    assign instr_data_o  = r_data;
    assign instr_pc_o    = r_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (((r_state == ST_FETCH) || (r_state == ST_FLUSH)) && !r_valid &&
                     instr_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: bench-side memory model, expected-instruction queue, redirect/reset tracking.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_data_o     (instr_data_o),
        .instr_pc_o       (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0, n_err = 0, n_gnt = 0, n_deliv = 0;
    int          gnt_mode, wait_cnt;
    bit          ready_cfg, rsp_hold, rst_cfg, stale_pend, prev_req, prev_gnt, chk_noval;
    logic [31:0] prev_addr, m_pc;
    exp_t        exp_q[$];
    logic [31:0] mem_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_req",   32'(imem_req_o),    32'd0);
        check("rst_addr",  imem_addr_o,        RST_PC);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_data",  instr_data_o,       32'd0);
        check("rst_pc",    instr_pc_o,         32'd0);
    endtask

    // One cycle: score decode handshake, drive memory response, grant, optional redirect
    task automatic step(input bit redir, input logic [31:0] tgt);
        exp_t e;
        bit   g;
        @(negedge clk_i);
        rst_i = rst_cfg;
        if (rst_cfg) begin
            exp_q.delete();
            m_pc       = RST_PC;
            stale_pend = 1'b0;
            prev_req   = 1'b0;
            wait_cnt   = 0;
        end else begin
            if (chk_noval) check("valid_after_redirect", 32'(instr_valid_o), 32'd0);
            if (instr_valid_o && ready_cfg) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc",   instr_pc_o,   e.pc);
                    check("instr_data", instr_data_o, e.data);
                    n_deliv++;
                end
            end
        end
        chk_noval     = 1'b0;
        instr_ready_i = ready_cfg;
        if (!rsp_hold && mem_q.size() != 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        if (prev_req && !prev_gnt && !rst_cfg) begin
            check("req_held",  32'(imem_req_o), 32'd1);
            check("addr_held", imem_addr_o,     prev_addr);
        end
        g = 1'b0;
        if (imem_req_o) begin
            case (gnt_mode)
                1:       g = 1'b1;
                2:       g = (wait_cnt >= 3);
                default: g = 1'b0;
            endcase
        end
        wait_cnt   = (imem_req_o && !g) ? wait_cnt + 1 : 0;
        imem_gnt_i = g;
        if (g) begin
            mem_q.push_back(imem_addr_o);
            n_gnt++;
            if (stale_pend) begin
                stale_pend = 1'b0;
            end else if (!redir) begin
                check("fetch_addr", imem_addr_o, m_pc);
                e.pc   = m_pc;
                e.data = mem_word(m_pc);
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        if (redir) begin
            exp_q.delete();
            m_pc = {tgt[31:2], 2'b00};
            if (imem_req_o && !g) stale_pend = 1'b1;
            chk_noval = 1'b1;
        end
        prev_req  = imem_req_o;
        prev_gnt  = g;
        prev_addr = imem_addr_o;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    initial begin
        int unsigned g0, d0;
        rst_i = 1'b1; rst_cfg = 1'b1;
        redirect_valid_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
        gnt_mode = 0; wait_cnt = 0; ready_cfg = 1'b0; rsp_hold = 1'b0;
        stale_pend = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; chk_noval = 1'b0;
        prev_addr = '0; m_pc = RST_PC;
        #2 check_reset();
        step_n(2);

        // Backpressure straight out of reset: only two fetches may be in the stage
        rst_cfg = 1'b0; gnt_mode = 1; ready_cfg = 1'b0;
        g0 = n_gnt;
        step_n(10);
        check("bp_grants",  32'(n_gnt - g0),    32'd2);
        check("bp_req_low", 32'(imem_req_o),    32'd0);
        check("bp_valid",   32'(instr_valid_o), 32'd1);
        check("bp_head_pc", instr_pc_o,         RST_PC);

        // Release: in-order delivery, then one instruction per cycle
        ready_cfg = 1'b1;
        step_n(6);
        d0 = n_deliv;
        step_n(10);
        check("throughput", 32'(n_deliv - d0), 32'd10);

        // Slow grant: request and address must hold until granted
        gnt_mode = 2;
        step_n(16);
        step_n(1);
        step(1'b1, 32'h0000_0300);
        step_n(20);

        // Redirect with two responses outstanding
        gnt_mode = 1;
        step_n(4);
        rsp_hold = 1'b1;
        step_n(4);
        check("outst_req_low", 32'(imem_req_o), 32'd0);
        step(1'b1, 32'h0000_0203);
        rsp_hold = 1'b0;
        d0 = n_deliv;
        step_n(10);
        check("redirect_deliv", 32'(n_deliv > d0), 32'd1);

        // PC wraps at the top of the address space
        step(1'b1, 32'hFFFF_FFFC);
        step_n(10);

        // Reset mid-burst with responses still in flight
        rsp_hold = 1'b1;
        step_n(3);
        rsp_hold = 1'b0;
        rst_cfg  = 1'b1;
        step_n(1);
        check_reset();
        rst_cfg = 1'b0;
        step_n(1);
        check("late_rsp_valid", 32'(instr_valid_o), 32'd0);
        step_n(12);

        // Drain
        gnt_mode = 0;
        step_n(8);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
